bus_maestro: RTL and testbench

Synchronous bus master for the CPUCR asynchronous memory bus. Converts single-cycle request/acknowledge transactions from the CPU core, or from a loader, into properly sequenced read and write cycles. It drives the 16-bit address bus, the bidirectional 8-bit data bus and the read/write strobe `LE` (1 = read, 0 = write; the memory captures data on the falling edge of `LE`). It is the initiator end of the interface served by the main memory.

---
 rtl/cpucr_bus_pkg.sv | 20 ++
 rtl/bus_espera.sv | 25 ++
 rtl/bus_maestro.sv | 129 ++++++++++++
 tb/tb_bus_maestro.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpucr_bus_pkg.sv
// Shared CPUCR bus encodings: master FSM states and LE strobe levels.
// Reused by the bus master, the memory and the bench.
package cpucr_bus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAddr   = 2'd1,
    StAccess = 2'd2,
    StFin    = 2'd3
  } bus_state_e;

  localparam logic LE_READ  = 1'b1;
  localparam logic LE_WRITE = 1'b0;

  // ACCESS lasts WAIT_CYCLES cycles, so the counter starts one below it.
  function automatic logic [3:0] wait_init(input int unsigned wait_cycles);
    return 4'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/bus_espera.sv
// Loadable 4-bit down-counter timing the ACCESS phase of a bus cycle.
module bus_espera (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [3:0] i_init,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_init;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd0);

endmodule

// File: rtl/bus_maestro.sv
// CPUCR asynchronous memory bus master: IDLE/ADDR/ACCESS/FIN byte sequencing.
// Optional word (two-byte) access is enabled by defining CPUCR_BUS_WORD_EN.
module bus_maestro
  import cpucr_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
`ifdef CPUCR_BUS_WORD_EN
  input  logic        word,
`endif
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [15:0] Direccion,
  inout  wire  [7:0]  Datos,
  output logic        LE
);

  bus_state_e  r_state;
  bus_state_e  w_state_d;
  logic        r_we;
  logic        r_word;
  logic        r_hi;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_dir;
  logic [7:0]  r_dout;
  logic        r_oe;
  logic        r_le;
  logic [15:0] r_rdata;
  logic        w_done;
  logic        w_last;

  bus_espera u_espera (
    .clk    (clk),
    .reset  (reset),
    .i_load (r_state == StAddr),
    .i_en   (r_state == StAccess),
    .i_init (wait_init(WAIT_CYCLES)),
    .o_done (w_done)
  );

  always_comb begin
    w_state_d = r_state;
    w_last    = !r_word || r_hi;
    unique case (r_state)
      StIdle:   if (req) w_state_d = StAddr;
      StAddr:   w_state_d = StAccess;
      StAccess: if (w_done) w_state_d = StFin;
      StFin:    w_state_d = w_last ? StIdle : StAddr;
      default:  w_state_d = StIdle;
    endcase
  end

  // LE, the data enable and the address are set one edge ahead of the phase
  // they belong to, so every bus pin comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_word  <= 1'b0;
      r_hi    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_dir   <= 16'h0000;
      r_dout  <= 8'h00;
      r_oe    <= 1'b0;
      r_le    <= LE_READ;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        StIdle: begin
          if (req) begin
            r_we    <= we;
`ifdef CPUCR_BUS_WORD_EN
            r_word  <= word;
`else
            r_word  <= 1'b0;
`endif
            r_hi    <= 1'b0;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_dir   <= addr;
            r_dout  <= wdata[7:0];
            r_oe    <= we;
            r_le    <= LE_READ;
          end
        end
        StAddr: begin
          if (r_we) r_le <= LE_WRITE;
        end
        StAccess: begin
          if (w_done) begin
            r_le <= LE_READ;
            if (!r_we) begin
              if (r_hi) r_rdata[15:8] <= Datos;
              else      r_rdata       <= {8'h00, Datos};
            end
          end
        end
        StFin: begin
          if (w_last) begin
            r_oe <= 1'b0;
          end else begin
            r_hi   <= 1'b1;
            r_dir  <= r_addr + 16'd1;
            r_dout <= r_wdata[15:8];
          end
        end
        default: ;
      endcase
    end
  end

  assign Datos     = r_oe ? r_dout : 8'hzz;
  assign LE        = r_le;
  assign Direccion = r_dir;
  assign rdata     = r_rdata;
  assign ack       = (r_state == StFin) && w_last;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_bus_maestro.sv
// Directed bench for bus_maestro: a W=1 and a W=4 master, each with a byte memory model.
module tb_bus_maestro;
  import cpucr_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req_a, req_b, we, word;
  logic [15:0] addr, wdata;
  logic [15:0] rdata_a, rdata_b, dir_a, dir_b;
  logic        ack_a, ack_b, busy_a, busy_b, le_a, le_b;
  wire  [7:0]  datos_a, datos_b;
  logic        rd_en_a, rd_en_b;
  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];
  int          fall_a = 0;
  int          fall_b = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  bus_maestro #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
`ifdef CPUCR_BUS_WORD_EN
    .word(word),
`endif
    .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .Direccion(dir_a), .Datos(datos_a), .LE(le_a)
  );

  bus_maestro #(.WAIT_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
`ifdef CPUCR_BUS_WORD_EN
    .word(word),
`endif
    .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .Direccion(dir_b), .Datos(datos_b), .LE(le_b)
  );

  // Memory: writes on the falling edge of LE, drives reads only while enabled by the bench.
  assign datos_a = (rd_en_a && le_a == LE_READ) ? mem_a[dir_a] : 8'hzz;
  assign datos_b = (rd_en_b && le_b == LE_READ) ? mem_b[dir_b] : 8'hzz;
  always @(negedge le_a) begin mem_a[dir_a] <= datos_a; fall_a <= fall_a + 1; end
  always @(negedge le_b) begin mem_b[dir_b] <= datos_b; fall_b <= fall_b + 1; end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit on_b, input bit w, input logic [15:0] a, input logic [15:0] d);
    we    = w;
    addr  = a;
    wdata = d;
    if (on_b) req_b = 1'b1;
    else      req_a = 1'b1;
  endtask

  // Returns the cycle (1 = ADDR) in which ack rose and how many cycles LE was low.
  task automatic wait_ack(input bit on_b, output int cyc, output int le_low);
    cyc    = 0;
    le_low = 0;
    do begin
      step();
      cyc++;
      if (cyc == 1) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
      if ((on_b ? le_b : le_a) == LE_WRITE) le_low++;
    end while (!(on_b ? ack_b : ack_a) && cyc < 40);
  endtask

  initial begin
    int cyc, low, base, acks, ack1, ack2;
    logic [7:0] old;
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0; word = 1'b0;
    addr = 16'h0000; wdata = 16'h0000; rd_en_a = 1'b0; rd_en_b = 1'b0;
    repeat (3) step();
    check("rst_le", 32'(le_a), 32'h1);
    check("rst_dir", 32'(dir_a), 32'h0);
    check("rst_rdata", 32'(rdata_a), 32'h0);
    check("rst_ack", 32'(ack_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_le_b", 32'(le_b), 32'h1);
    reset = 1'b0;
    step();

    // Byte write A5 -> 0010, W=1, cycle by cycle.
    base = fall_a;
    issue(0, 1'b1, 16'h0010, 16'h12A5);
    step(); req_a = 1'b0;
    check("wr_addr_busy", 32'(busy_a), 32'h1);
    check("wr_addr_dir", 32'(dir_a), 32'h0010);
    check("wr_addr_le", 32'(le_a), 32'h1);
    check("wr_addr_data", 32'(datos_a), 32'h00A5);
    step();
    check("wr_access_le", 32'(le_a), 32'h0);
    step();
    check("wr_fin_ack", 32'(ack_a), 32'h1);
    check("wr_fin_le", 32'(le_a), 32'h1);
    step();
    check("wr_idle_ack", 32'(ack_a), 32'h0);
    check("wr_idle_busy", 32'(busy_a), 32'h0);
    check("wr_falls", 32'(fall_a - base), 32'h1);
    check("wr_mem", 32'(mem_a[16'h0010]), 32'h00A5);

    // Read-back of 0010.
    rd_en_a = 1'b1;
    base = fall_a;
    issue(0, 1'b0, 16'h0010, 16'h0000);
    wait_ack(0, cyc, low);
    check("rd_ack_cycle", 32'(cyc), 32'd3);
    check("rd_rdata", 32'(rdata_a), 32'h00A5);
    check("rd_le_low", 32'(low), 32'd0);
    step();
    rd_en_a = 1'b0;
    check("rd_falls", 32'(fall_a - base), 32'h0);

    // W=4: write 3C -> 0200, then read it back.
    issue(1, 1'b1, 16'h0200, 16'h003C);
    wait_ack(1, cyc, low);
    check("w4_wr_ack_cycle", 32'(cyc), 32'd6);
    check("w4_wr_le_low", 32'(low), 32'd4);
    step();
    check("w4_wr_mem", 32'(mem_b[16'h0200]), 32'h003C);
    rd_en_b = 1'b1;
    base = fall_b;
    issue(1, 1'b0, 16'h0200, 16'h0000);
    wait_ack(1, cyc, low);
    check("w4_rd_ack_cycle", 32'(cyc), 32'd6);
    check("w4_rd_rdata", 32'(rdata_b), 32'h003C);
    check("w4_rd_le_low", 32'(low), 32'd0);
    step();
    rd_en_b = 1'b0;
    check("w4_rd_falls", 32'(fall_b - base), 32'h0);

    // Second req while busy is ignored.
    old  = mem_a[16'h0040];
    acks = 0;
    issue(0, 1'b1, 16'h0030, 16'h0011);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) begin req_a = 1'b0; addr = 16'h0040; wdata = 16'h0022; end
      if (c == 2) req_a = 1'b1;
      if (c == 3) req_a = 1'b0;
      if (ack_a) acks++;
    end
    check("busy_req_acks", 32'(acks), 32'd1);
    check("busy_req_mem1", 32'(mem_a[16'h0030]), 32'h0011);
    check("busy_req_mem2", 32'(mem_a[16'h0040]), 32'(old));

    // Reset during ACCESS of a write.
    base = fall_a;
    issue(0, 1'b1, 16'h0020, 16'h0077);
    step(); req_a = 1'b0;
    step();
    check("rst_acc_le_low", 32'(le_a), 32'h0);
    reset = 1'b1;
    step();
    check("rst_acc_le", 32'(le_a), 32'h1);
    check("rst_acc_ack", 32'(ack_a), 32'h0);
    check("rst_acc_busy", 32'(busy_a), 32'h0);
    check("rst_acc_dir", 32'(dir_a), 32'h0);
    check("rst_acc_rdata", 32'(rdata_a), 32'h0);
    reset = 1'b0;
    repeat (3) step();
    check("rst_acc_falls", 32'(fall_a - base), 32'h1);
    check("rst_acc_noack", 32'(ack_a), 32'h0);

    // Reset during ADDR of a write: no strobe at all.
    base = fall_b;
    issue(1, 1'b1, 16'h0300, 16'h0099);
    step(); req_b = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (6) step();
    check("rst_addr_falls", 32'(fall_b - base), 32'h0);
    check("rst_addr_busy", 32'(busy_b), 32'h0);
    check("rst_addr_le", 32'(le_b), 32'h1);

    // req held high: write C3 -> 0001 then read; acks 4 cycles apart.
    acks = 0; ack1 = 0; ack2 = 0;
    issue(0, 1'b1, 16'h0001, 16'h00C3);
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) we = 1'b0;
      if (c == 4) rd_en_a = 1'b1;
      if (c == 7) req_a = 1'b0;
      if (ack_a) begin
        acks++;
        if (acks == 1) ack1 = c;
        else           ack2 = c;
      end
    end
    rd_en_a = 1'b0;
    check("b2b_acks", 32'(acks), 32'd2);
    check("b2b_ack1", 32'(ack1), 32'd3);
    check("b2b_ack2", 32'(ack2), 32'd7);
    check("b2b_mem", 32'(mem_a[16'h0001]), 32'h00C3);
    check("b2b_rdata", 32'(rdata_a), 32'h00C3);

`ifdef CPUCR_BUS_WORD_EN
    // Word write BEEF -> FFFF wraps the high byte to 0000.
    base = fall_a;
    word = 1'b1;
    issue(0, 1'b1, 16'hFFFF, 16'hBEEF);
    wait_ack(0, cyc, low);
    check("word_wr_ack_cycle", 32'(cyc), 32'd6);
    step();
    check("word_wr_lo", 32'(mem_a[16'hFFFF]), 32'h00EF);
    check("word_wr_hi", 32'(mem_a[16'h0000]), 32'h00BE);
    check("word_wr_falls", 32'(fall_a - base), 32'd2);
    rd_en_a = 1'b1;
    acks = 0;
    issue(0, 1'b0, 16'hFFFF, 16'h0000);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) req_a = 1'b0;
      if (ack_a) begin
        acks++;
        check("word_rd_ack_cycle", 32'(c), 32'd6);
      end
    end
    rd_en_a = 1'b0;
    word = 1'b0;
    check("word_rd_acks", 32'(acks), 32'd1);
    check("word_rd_rdata", 32'(rdata_a), 32'hBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
